// File: rtl/cmul_triv_pipe.sv
// Multiplies packed complex float samples by {1, -j, -1, +j} via swap/sign flip, into a 2-entry output FIFO.
// Define CMUL_TRIV_AUTOSEQ_EN to build the index-driven rotation sequencer (rot_auto selects it).
module cmul_triv_pipe #(
  parameter int FW    = 32,
  parameter int LANES = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [LANES*FW-1:0]   s_re,
  input  logic [LANES*FW-1:0]   s_im,
  input  logic [2*LANES-1:0]    s_rot,
  input  logic                  s_last,
  input  logic                  rot_auto,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [LANES*FW-1:0]   m_re,
  output logic [LANES*FW-1:0]   m_im,
  output logic                  m_last
);

  localparam int W = LANES * FW;

  logic          push;
  logic          pop;
  logic [W-1:0]  rot_re;
  logic [W-1:0]  rot_im;

  logic [W-1:0]  buf_re   [2];
  logic [W-1:0]  buf_im   [2];
  logic          buf_last [2];
  logic          wr_ptr;
  logic          rd_ptr;
  logic [1:0]    count;

  // Ready comes only from the registered fill level, so downstream stalls never reach s_ready in the same cycle.
  assign s_ready = ~count[1];
  assign m_valid = (count != 2'd0);
  assign push    = s_valid & s_ready;
  assign pop     = m_valid & m_ready;

`ifdef CMUL_TRIV_AUTOSEQ_EN
  logic [1:0] phase;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase <= 2'd0;
    end else if (push) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      phase <= s_last ? 2'd0 : phase + 2'd1;
    end
  end
`else
  logic rot_auto_unused;
  assign rot_auto_unused = rot_auto;
`endif

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [FW-1:0] a;
    logic [FW-1:0] b;
    logic [FW-1:0] neg_a;
    logic [FW-1:0] neg_b;
    logic [1:0]    code;
    logic [FW-1:0] out_re;
    logic [FW-1:0] out_im;

    assign a     = s_re[l*FW +: FW];
    assign b     = s_im[l*FW +: FW];
    assign neg_a = {~a[FW-1], a[FW-2:0]};
    assign neg_b = {~b[FW-1], b[FW-2:0]};

`ifdef CMUL_TRIV_AUTOSEQ_EN
    localparam logic [1:0] LANE_MOD = 2'(l);
    logic [1:0] auto_code;
    // Two-bit product wraps naturally, giving (l * phase) mod 4.
    assign auto_code = phase * LANE_MOD;
    assign code      = rot_auto ? auto_code : s_rot[2*l +: 2];
`else
    assign code = s_rot[2*l +: 2];
`endif

    always_comb begin
      // NOTE: default both outputs first so no path through the case can infer a latch.
      out_re = a;
      out_im = b;
      case (code)
        2'd1:    begin out_re = b;     out_im = neg_a; end
        2'd2:    begin out_re = neg_a; out_im = neg_b; end
        2'd3:    begin out_re = neg_b; out_im = a;     end
        default: begin out_re = a;     out_im = b;     end
      endcase
    end

    assign rot_re[l*FW +: FW] = out_re;
    assign rot_im[l*FW +: FW] = out_im;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the two buffer entries are reset because outputs must read zero after reset.
      for (int i = 0; i < 2; i++) begin
        buf_re[i]   <= '0;
        buf_im[i]   <= '0;
        buf_last[i] <= 1'b0;
      end
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        buf_re[wr_ptr]   <= rot_re;
        buf_im[wr_ptr]   <= rot_im;
        buf_last[wr_ptr] <= s_last;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign m_re   = buf_re[rd_ptr];
  assign m_im   = buf_im[rd_ptr];
  assign m_last = buf_last[rd_ptr];

endmodule

// File: tb/tb_cmul_triv_pipe.sv
// Directed bench for cmul_triv_pipe: rotation codes, sign-only edits, backpressure, sequencer and mid-stream reset.
module tb_cmul_triv_pipe;

  localparam int FW    = 32;
  localparam int LANES = 3;
  localparam int W     = FW * LANES;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                s_valid;
  logic                s_ready;
  logic [W-1:0]        s_re;
  logic [W-1:0]        s_im;
  logic [2*LANES-1:0]  s_rot;
  logic                s_last;
  logic                rot_auto;
  logic                m_valid;
  logic                m_ready;
  logic [W-1:0]        m_re;
  logic [W-1:0]        m_im;
  logic                m_last;

  int checks = 0;
  int errors = 0;

  cmul_triv_pipe #(.FW(FW), .LANES(LANES)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .s_re     (s_re),
    .s_im     (s_im),
    .s_rot    (s_rot),
    .s_last   (s_last),
    .rot_auto (rot_auto),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_re     (m_re),
    .m_im     (m_im),
    .m_last   (m_last)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Hand-computed results of rotating (1.0, 2.0) = (0x3F800000, 0x40000000) by each code.
  function automatic logic [FW-1:0] one_two_re(input int code);
    case (code)
      0:       return 32'h3F800000;
      1:       return 32'h40000000;
      2:       return 32'hBF800000;
      default: return 32'hC0000000;
    endcase
  endfunction

  function automatic logic [FW-1:0] one_two_im(input int code);
    case (code)
      0:       return 32'h40000000;
      1:       return 32'hBF800000;
      2:       return 32'hC0000000;
      default: return 32'h3F800000;
    endcase
  endfunction

  // Called at a falling edge; returns at the next falling edge with the beat at the FIFO head.
  task automatic send(input logic [W-1:0] re, input logic [W-1:0] im,
                      input logic [2*LANES-1:0] rot, input logic last);
    s_re    = re;
    s_im    = im;
    s_rot   = rot;
    s_last  = last;
    s_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  initial begin : stim
    int accepted;
    logic [FW-1:0] got [$];
    int lane1_codes [5];
    int lane2_codes [5];
    lane1_codes = '{0, 1, 2, 3, 0};
    lane2_codes = '{0, 2, 0, 2, 0};

    rst_n    = 1'b0;
    s_valid  = 1'b0;
    s_re     = '0;
    s_im     = '0;
    s_rot    = '0;
    s_last   = 1'b0;
    rot_auto = 1'b0;
    m_ready  = 1'b1;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check("reset_m_valid", m_valid, 1'b0);
    check("reset_m_re", m_re, '0);
    check("reset_m_im", m_im, '0);
    check("reset_m_last", m_last, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_s_ready", s_ready, 1'b1);

    // Codes 1/3/2 on lanes 0/1/2, all with input (1.0, 2.0)
    send({3{32'h3F800000}}, {3{32'h40000000}}, {2'd2, 2'd3, 2'd1}, 1'b0);
    check("codes_m_valid", m_valid, 1'b1);
    check("codes_m_re", m_re, {32'hBF800000, 32'hC0000000, 32'h40000000});
    check("codes_m_im", m_im, {32'hC0000000, 32'h3F800000, 32'hBF800000});
    check("codes_m_last", m_last, 1'b0);

    // Sign-only edits on zero, NaN, Inf and denormal, with s_last
    send({32'h80000000, 32'hFF800000, 32'h00000000},
         {32'h7F800000, 32'h00000001, 32'h7FC00000},
         {2'd1, 2'd0, 2'd2}, 1'b1);
    check("special_m_re", m_re, {32'h7F800000, 32'hFF800000, 32'h80000000});
    check("special_m_im", m_im, {32'h00000000, 32'h00000001, 32'hFFC00000});
    check("special_m_last", m_last, 1'b1);

    @(negedge clk);
    check("drained_m_valid", m_valid, 1'b0);

    // Backpressure: four offered beats with the sink stalled
    m_ready  = 1'b0;
    accepted = 0;
    for (int i = 1; i <= 4; i++) begin
      s_valid = 1'b1;
      s_re    = {3{32'(i)}};
      s_im    = {3{32'(i + 256)}};
      s_rot   = '0;
      if (s_ready) accepted++;
      @(posedge clk);
      @(negedge clk);
    end
    s_valid = 1'b0;
    check("bp_accepted", accepted, 2);
    check("bp_s_ready_low", s_ready, 1'b0);
    check("bp_head_stable_re", m_re, {3{32'd1}});
    check("bp_head_stable_im", m_im, {3{32'd257}});

    m_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (m_valid) got.push_back(m_re[FW-1:0]);
      @(negedge clk);
    end
    check("bp_out_count", got.size(), 2);
    if (got.size() == 2) begin
      check("bp_out_first", got[0], 32'd1);
      check("bp_out_second", got[1], 32'd2);
    end
    check("bp_s_ready_back", s_ready, 1'b1);

    // Back-to-back beats at full rate, frame ends on the last one
    for (int i = 0; i < 4; i++) begin
      s_valid = 1'b1;
      s_re    = {3{32'(16 + i)}};
      s_im    = '0;
      s_rot   = '0;
      s_last  = (i == 3);
      @(posedge clk);
      @(negedge clk);
      check("tp_m_valid", m_valid, 1'b1);
      check("tp_m_re", m_re[FW-1:0], 32'(16 + i));
      check("tp_m_last", m_last, (i == 3));
      check("tp_s_ready", s_ready, 1'b1);
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    @(negedge clk);

`ifdef CMUL_TRIV_AUTOSEQ_EN
    // Sequencer: 5-beat frame then the first beat of the next frame
    rot_auto = 1'b1;
    for (int i = 0; i < 5; i++) begin
      send({3{32'h3F800000}}, {3{32'h40000000}}, 6'b111111, (i == 4));
      check("seq_lane0_re", m_re[0 +: FW], one_two_re(0));
      check("seq_lane1_re", m_re[FW +: FW], one_two_re(lane1_codes[i]));
      check("seq_lane1_im", m_im[FW +: FW], one_two_im(lane1_codes[i]));
      check("seq_lane2_re", m_re[2*FW +: FW], one_two_re(lane2_codes[i]));
      check("seq_lane2_im", m_im[2*FW +: FW], one_two_im(lane2_codes[i]));
    end
    send({3{32'h3F800000}}, {3{32'h40000000}}, 6'b111111, 1'b0);
    check("seq_next_frame_re", m_re, {3{32'h3F800000}});
    check("seq_next_frame_im", m_im, {3{32'h40000000}});
`else
    // Without the sequencer, rot_auto is ignored and s_rot applies
    rot_auto = 1'b1;
    send({3{32'h3F800000}}, {3{32'h40000000}}, {2'd2, 2'd2, 2'd2}, 1'b0);
    check("noseq_neg_re", m_re, {3{32'hBF800000}});
    check("noseq_neg_im", m_im, {3{32'hC0000000}});
    check("noseq_lane1_ignored_rot_auto", lane1_codes[1] + lane2_codes[1], 3);
`endif
    @(negedge clk);

    // Reset with two beats buffered; the sequencer phase has also advanced
    m_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      s_valid = 1'b1;
      s_re    = {3{32'h3F800000}};
      s_im    = {3{32'h40000000}};
      s_rot   = '0;
      @(posedge clk);
      @(negedge clk);
    end
    s_valid = 1'b0;
    check("prereset_s_ready", s_ready, 1'b0);
    rst_n = 1'b0;
    #1;
    check("midreset_m_valid", m_valid, 1'b0);
    check("midreset_m_re", m_re, '0);
    check("midreset_m_im", m_im, '0);
    check("midreset_m_last", m_last, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("midreset_s_ready", s_ready, 1'b1);
    check("midreset_empty", m_valid, 1'b0);
    m_ready = 1'b1;

`ifdef CMUL_TRIV_AUTOSEQ_EN
    send({3{32'h3F800000}}, {3{32'h40000000}}, 6'b111111, 1'b0);
`else
    rot_auto = 1'b0;
    send({3{32'h3F800000}}, {3{32'h40000000}}, 6'b000000, 1'b0);
`endif
    check("postreset_beat_valid", m_valid, 1'b1);
    check("postreset_beat_re", m_re, {3{32'h3F800000}});
    check("postreset_beat_im", m_im, {3{32'h40000000}});

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog observed timeout expected completion");
    $fatal(1, "bench timed out");
  end

endmodule

// File: doc/cmul_triv_pipe.md
# cmul_triv_pipe

Streaming multiplier of packed IEEE-754 complex samples by the trivial twiddles {1, −j, −1, +j}, implemented purely by real/imag swap and sign-bit inversion. It generalises the fixed ×1/×−1 sign-flip unit in the radix butterfly path. It adds:
- a parametrised float width and lane count;
- a per-lane rotation code, or an optional auto-sequenced code derived from the sample index;
- a valid/ready handshake with a 2-entry output buffer.

It sits between butterfly output registers and the next FFT stage.

## Interface
- FW, 32, float word width; sign bit is bit FW−1
- LANES, 3, complex samples per beat (lane 0 at LSBs)
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- s_valid  in  1  input beat valid
- s_ready  out  1  input beat accepted when s_valid & s_ready
- s_re  in  LANES*FW  real parts
- s_im  in  LANES*FW  imaginary parts
- s_rot  in  2*LANES  per-lane rotation code: 0 ×1, 1 ×(−j), 2 ×(−1), 3 ×(+j)
- s_last  in  1  last beat of frame
- rot_auto  in  1  1 = use sequencer codes, ignore s_rot (static per frame)
- m_valid  out  1  output beat valid
- m_ready  in  1  downstream accept
- m_re, m_im  out  LANES*FW  rotated samples
- m_last  out  1  s_last delayed with its beat

## Operation
- Per lane, with input (a, b) = (re, im) and neg(x) = x with MSB inverted:
  - code 0 → (a, b)
  - code 1 → (b, neg(a))
  - code 2 → (neg(a), neg(b))
  - code 3 → (neg(b), a)
- The sign bit is inverted unconditionally, including for ±0, Inf and NaN. No exponent or mantissa bit ever changes.
- Rotation is computed combinationally on the accepted beat. The result and s_last are written into a 2-entry FIFO (wr/rd pointers plus a 2-bit count).
- Head of FIFO drives m_re/m_im/m_last; m_valid = count≠0.
- s_ready = count<2, from registered state only; it never depends on m_ready combinationally.
- Push and pop in the same cycle: count unchanged; both pointers advance.
- Sequencer (see Configuration):
  - 2-bit phase counter; lane l code = (l·phase) mod 4.
  - phase increments by 1 (mod 4) on each accepted beat.
  - phase clears to 0 on an accepted beat with s_last=1.
  - phase is unaffected when no beat is accepted.
- Reset (any time, including mid-frame):
  - count=0, pointers=0, phase=0.
  - m_valid=0, m_last=0, m_re=m_im=0.
  - s_ready=1 in the cycle after rst_n deasserts.
  - Buffered beats are discarded.

## Timing
- Latency: a beat accepted at edge t is presented on m_valid after edge t (visible cycle t+1) if the FIFO was empty.
- Throughput: 1 beat/cycle while m_ready=1 continuously.
- m_ready low: at most 2 beats are absorbed, then s_ready falls the cycle after count reaches 2.
- The stream is stalled with no loss.
- Output stability: m_re/m_im/m_last are held stable while m_valid=1 and m_ready=0.

## Configuration
- Macro: CMUL_TRIV_AUTOSEQ_EN.
- Defined: the phase counter and auto code generation are built. rot_auto=1 selects sequencer codes.
- Undefined: no counter is built, rot_auto is ignored, and s_rot is always used. The port list is identical in both builds.

## Test plan
- Codes per lane: lane0 (0x3F800000, 0x40000000) code 1 → (0x40000000, 0xBF800000). Code 3 → (0xC0000000, 0x3F800000). Code 2 → (0xBF800000, 0xC0000000).
- Zero/NaN: re=0x00000000, im=0x7FC00000, code 2 → (0x80000000, 0xFFC00000).
- Backpressure: m_ready=0 with s_valid=1 for 4 cycles → exactly 2 beats accepted and s_ready=0. Raise m_ready → beats emerge in order, none lost or duplicated.
- Autoseq (macro on), LANES=3, rot_auto=1, 5-beat frame with s_last on beat 5:
  - lane 2 codes 0, 2, 0, 2, 0
  - lane 1 codes 0, 1, 2, 3, 0
  - next frame starts at phase 0
- Reset mid-stream with 2 beats buffered → m_valid=0, outputs zero. First post-reset beat uses phase 0.
- Macro off: rot_auto=1, s_rot=all 2 → every lane negated.
